// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Purpose  : Pointer-and-flag controller for a register-based FIFO. Converts
//            write/read requests into one-hot per-entry write strobes and a
//            read-select code, and tracks occupancy, full/empty status and
//            sticky overflow/underflow errors. The storage array it drives
//            holds no control logic of its own.
// Ports    : CK    - clock, rising edge
//            CLR   - synchronous active-high reset (priority over all inputs)
//            WR    - write request
//            RD    - read request
//            WE    - one-hot write strobe per entry (combinational)
//            RSEL  - read-select code, equals the read pointer (registered)
//            COUNT - occupancy 0..DEPTH (registered)
//            EMPTY - COUNT==0 (registered)
//            FULL  - COUNT==DEPTH (registered)
//            OVF   - sticky overflow error (registered)
//            UNF   - sticky underflow error (registered)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             WR,
    input  logic             RD,
    output logic [DEPTH-1:0] WE,
    output logic [AW-1:0]    RSEL,
    output logic [AW:0]      COUNT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVF,
    output logic             UNF
);

    localparam logic [AW:0] c_CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_CNT_ONE  = (AW+1)'(1);

    logic [AW-1:0] r_wp_q;
    logic [AW-1:0] r_rp_q;
    logic [AW:0]   r_cnt_q;
    logic          r_empty_q;
    logic          r_full_q;
    logic          r_ovf_q;
    logic          r_unf_q;

    logic [AW-1:0] w_wp_d;
    logic [AW-1:0] w_rp_d;
    logic [AW:0]   w_cnt_d;
    logic          w_wa;
    logic          w_ra;

    // A write at FULL is still accepted when a read frees the head entry in
    // the same cycle; the head is overwritten at the edge after being read.
    assign w_wa = WR & (~r_full_q | RD) & ~CLR;
    // No fall-through: a read at EMPTY is rejected even alongside a write.
    assign w_ra = RD & ~r_empty_q & ~CLR;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_we
            assign WE[i] = w_wa & (r_wp_q == AW'(i));
        end
    endgenerate

    always_comb begin
        w_wp_d  = r_wp_q;
        w_rp_d  = r_rp_q;
        w_cnt_d = r_cnt_q;
        if (w_wa) begin
            w_wp_d = r_wp_q + 1'b1;
        end
        if (w_ra) begin
            w_rp_d = r_rp_q + 1'b1;
        end
        if (w_wa && !w_ra) begin
            w_cnt_d = r_cnt_q + c_CNT_ONE;
        end else if (w_ra && !w_wa) begin
            w_cnt_d = r_cnt_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            r_wp_q    <= '0;
            r_rp_q    <= '0;
            r_cnt_q   <= '0;
            r_empty_q <= 1'b1;
            r_full_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_unf_q   <= 1'b0;
        end else begin
            r_wp_q    <= w_wp_d;
            r_rp_q    <= w_rp_d;
            r_cnt_q   <= w_cnt_d;
            // Flags derive from the next count so they align with COUNT.
            r_empty_q <= (w_cnt_d == '0);
            r_full_q  <= (w_cnt_d == c_CNT_FULL);
            r_ovf_q   <= r_ovf_q | (WR & r_full_q & ~RD);
            r_unf_q   <= r_unf_q | (RD & r_empty_q);
        end
    end

    assign RSEL  = r_rp_q;
    assign COUNT = r_cnt_q;
    assign EMPTY = r_empty_q;
    assign FULL  = r_full_q;
    assign OVF   = r_ovf_q;
    assign UNF   = r_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Purpose  : Self-checking bench for fifo_ctrl: directed vector table, hand
//            sequences for wrap-around and mid-operation reset, then random
//            traffic checked against an occupancy/transaction-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             CK;
    logic             CLR;
    logic             WR;
    logic             RD;
    logic [DEPTH-1:0] WE;
    logic [AW-1:0]    RSEL;
    logic [AW:0]      COUNT;
    logic             EMPTY;
    logic             FULL;
    logic             OVF;
    logic             UNF;

    fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CK    (CK),
        .CLR   (CLR),
        .WR    (WR),
        .RD    (RD),
        .WE    (WE),
        .RSEL  (RSEL),
        .COUNT (COUNT),
        .EMPTY (EMPTY),
        .FULL  (FULL),
        .OVF   (OVF),
        .UNF   (UNF)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: occupancy plus total accepted writes/reads. The slot
    // written next is (writes mod DEPTH); the head slot is (reads mod DEPTH).
    int m_occ = 0;
    int m_nw  = 0;
    int m_nr  = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check WE against the model before the
    // edge, advance the model, then check registered outputs after the edge.
    task automatic step(input bit clr, input bit wr, input bit rd, output int we_seen);
        bit full_m, empty_m, wa, ra;
        int exp_we;
        @(negedge CK);
        CLR = clr; WR = wr; RD = rd;
        #1;
        full_m  = (m_occ == DEPTH);
        empty_m = (m_occ == 0);
        if (clr) begin
            exp_we = 0;
            m_occ = 0; m_nw = 0; m_nr = 0; m_ovf = 0; m_unf = 0;
        end else begin
            wa = wr && (!full_m || rd);
            ra = rd && !empty_m;
            exp_we = wa ? (1 << (m_nw % DEPTH)) : 0;
            if (wr && full_m && !rd) m_ovf = 1;
            if (rd && empty_m)       m_unf = 1;
            m_occ = m_occ + int'(wa) - int'(ra);
            m_nw  = m_nw + int'(wa);
            m_nr  = m_nr + int'(ra);
        end
        we_seen = int'(WE);
        check("model_WE", int'(WE), exp_we);
        @(posedge CK);
        #1;
        check("model_COUNT", int'(COUNT), m_occ);
        check("model_EMPTY", int'(EMPTY), int'(m_occ == 0));
        check("model_FULL",  int'(FULL),  int'(m_occ == DEPTH));
        check("model_RSEL",  int'(RSEL),  m_nr % DEPTH);
        check("model_OVF",   int'(OVF),   int'(m_ovf));
        check("model_UNF",   int'(UNF),   int'(m_unf));
    endtask

    typedef struct {
        bit clr, wr, rd;
        int we;                         // expected before the edge
        int rsel, cnt;                  // expected after the edge
        bit empty, full, ovf, unf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int we_seen;
        CLR = 1'b1; WR = 1'b0; RD = 1'b0;

        // Reset with requests active, fill, simultaneous at full, overflow,
        // drain across the pointer wrap, underflow, simultaneous at empty.
        vecs[0]  = '{1,1,1, 4'b0000, 0,0, 1,0,0,0};
        vecs[1]  = '{1,1,1, 4'b0000, 0,0, 1,0,0,0};
        vecs[2]  = '{0,1,0, 4'b0001, 0,1, 0,0,0,0};
        vecs[3]  = '{0,1,0, 4'b0010, 0,2, 0,0,0,0};
        vecs[4]  = '{0,1,0, 4'b0100, 0,3, 0,0,0,0};
        vecs[5]  = '{0,1,0, 4'b1000, 0,4, 0,1,0,0};
        vecs[6]  = '{0,1,1, 4'b0001, 1,4, 0,1,0,0};
        vecs[7]  = '{0,1,0, 4'b0000, 1,4, 0,1,1,0};
        vecs[8]  = '{0,0,1, 4'b0000, 2,3, 0,0,1,0};
        vecs[9]  = '{0,0,1, 4'b0000, 3,2, 0,0,1,0};
        vecs[10] = '{0,0,1, 4'b0000, 0,1, 0,0,1,0};
        vecs[11] = '{0,0,1, 4'b0000, 1,0, 1,0,1,0};
        vecs[12] = '{0,0,1, 4'b0000, 1,0, 1,0,1,1};
        vecs[13] = '{0,1,1, 4'b0010, 1,1, 0,0,1,1};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].clr, vecs[i].wr, vecs[i].rd, we_seen);
            check($sformatf("vec%0d_WE", i),    we_seen,      vecs[i].we);
            check($sformatf("vec%0d_RSEL", i),  int'(RSEL),   vecs[i].rsel);
            check($sformatf("vec%0d_COUNT", i), int'(COUNT),  vecs[i].cnt);
            check($sformatf("vec%0d_EMPTY", i), int'(EMPTY),  int'(vecs[i].empty));
            check($sformatf("vec%0d_FULL", i),  int'(FULL),   int'(vecs[i].full));
            check($sformatf("vec%0d_OVF", i),   int'(OVF),    int'(vecs[i].ovf));
            check($sformatf("vec%0d_UNF", i),   int'(UNF),    int'(vecs[i].unf));
        end

        // Wrap-around: from reset write 3, read 3, write 3, read 1.
        step(1, 0, 0, we_seen);
        for (int i = 0; i < 3; i++) step(0, 1, 0, we_seen);
        for (int i = 0; i < 3; i++) step(0, 0, 1, we_seen);
        check("wrap_RSEL_before", int'(RSEL), 3);
        step(0, 1, 0, we_seen); check("wrap_WE0", we_seen, 4'b1000);
        step(0, 1, 0, we_seen); check("wrap_WE1", we_seen, 4'b0001);
        step(0, 1, 0, we_seen); check("wrap_WE2", we_seen, 4'b0010);
        check("wrap_COUNT", int'(COUNT), 3);
        step(0, 0, 1, we_seen);
        check("wrap_RSEL_after", int'(RSEL), 0);
        check("wrap_COUNT2", int'(COUNT), 2);

        // Mid-operation reset with COUNT=2 and a write pending.
        step(1, 1, 0, we_seen);
        check("midrst_WE",    we_seen,      0);
        check("midrst_COUNT", int'(COUNT),  0);
        check("midrst_EMPTY", int'(EMPTY),  1);
        check("midrst_RSEL",  int'(RSEL),   0);
        step(0, 1, 0, we_seen);
        check("midrst_WE_after", we_seen, 4'b0001);

        // Random traffic, write-biased then read-biased phases, rare resets.
        for (int i = 0; i < 600; i++) begin
            bit c, w, r;
            int bias;
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            c = ($urandom_range(0, 63) == 0);
            w = ($urandom_range(0, 99) < bias);
            r = ($urandom_range(0, 99) < (100 - bias));
            step(c, w, r, we_seen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
